dmem: RTL and testbench

DMEM -- requirements
Module: dmem

---
 rtl/dmem.sv | 149 ++++++++++++++
 tb/tb_dmem.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem.sv
// CHIP-8 data memory: 4 KiB synchronous RAM with hex-font preload after reset
// and a single-outstanding request/ready handshake with optional wait states.
module dmem #(
    parameter logic [11:0] FONT_BASE   = 12'h050,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_signal,
    input  logic        dmem_we,
    input  logic [15:0] dmem_adr,
    input  logic [7:0]  dmem_wbus,
    output logic [7:0]  dmem_rbus,
    output logic        dmem_ready,
    output logic        dmem_err,
    output logic        init_done
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    // Glyphs 0..F, five rows each, first byte in the top bits.
    localparam logic [639:0] FONT = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    state_t      state_q, state_d;
    logic [6:0]  off_q, off_d;
    logic [15:0] adr_q, adr_d;
    logic        we_q, we_d;
    logic [7:0]  wbus_q, wbus_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [7:0]  rbus_q;

    logic [7:0]  mem [4096];
    logic        mem_we;
    logic [11:0] mem_a;
    logic [7:0]  mem_wd;
    logic        in_range;

    assign in_range   = (adr_q[15:12] == 4'h0);
    assign dmem_rbus  = rbus_q;
    assign dmem_ready = (state_q == RESP);
    assign dmem_err   = (state_q == RESP) && !in_range;
    assign init_done  = done_q;

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        adr_d   = adr_q;
        we_d    = we_q;
        wbus_d  = wbus_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        mem_we  = 1'b0;
        mem_a   = adr_q[11:0];
        mem_wd  = wbus_q;
        unique case (state_q)
            INIT: begin
                mem_we = 1'b1;
                mem_a  = FONT_BASE + 12'(off_q);
                mem_wd = FONT[(79 - int'(off_q)) * 8 +: 8];
                off_d  = off_q + 7'd1;
                if (off_q == 7'd79) begin
                    off_d   = 7'd0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (dmem_signal) begin
                    adr_d  = dmem_adr;
                    we_d   = dmem_we;
                    wbus_d = dmem_wbus;
                    cnt_d  = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES > 0) state_d = WAIT;
                    else                 state_d = ACCESS;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ACCESS;
            end
            ACCESS: begin
                mem_we  = we_q && in_range;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            off_q   <= 7'd0;
            adr_q   <= 16'h0000;
            we_q    <= 1'b0;
            wbus_q  <= 8'h00;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            rbus_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            wbus_q  <= wbus_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (state_q == ACCESS) begin
                if (!in_range)  rbus_q <= 8'h00;
                else if (we_q)  rbus_q <= wbus_q;
                else            rbus_q <= mem[adr_q[11:0]];
            end
        end
    end

    // No reset on the array: contents outside the font survive reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_a] <= mem_wd;
    end

endmodule

// File: tb/tb_dmem.sv
// Bench for dmem: reset/init timing, table vectors, back-to-back, wait
// states, reset during an access, and random traffic against a memory model.
module tb_dmem;

    logic clk = 1'b0;
    logic rst;
    logic sig, we, rdy, err, idn;
    logic [15:0] adr;
    logic [7:0] wb, rb;
    logic sig3, we3, rdy3, err3, idn3;
    logic [15:0] adr3;
    logic [7:0] wb3, rb3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem dut (
        .clk(clk), .rst(rst), .dmem_signal(sig), .dmem_we(we),
        .dmem_adr(adr), .dmem_wbus(wb), .dmem_rbus(rb),
        .dmem_ready(rdy), .dmem_err(err), .init_done(idn)
    );

    dmem #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .dmem_signal(sig3), .dmem_we(we3),
        .dmem_adr(adr3), .dmem_wbus(wb3), .dmem_rbus(rb3),
        .dmem_ready(rdy3), .dmem_err(err3), .init_done(idn3)
    );

    logic [7:0] font_rom [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0, 8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90, 8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0, 8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    // Reference memories for the two instances, with a known-contents flag.
    logic [7:0] rmem [2][4096];
    bit         rok  [2][4096];

    typedef struct {
        bit          w;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp_rb;
        bit          exp_er;
        bit          chk_rb;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_font();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 80; i++) begin
                rmem[d][12'h050 + i] = font_rom[i];
                rok[d][12'h050 + i]  = 1'b1;
            end
    endtask

    task automatic drive(input bit d3, input bit s, input bit w,
                         input logic [15:0] a, input logic [7:0] d);
        if (d3) begin
            sig3 = s; we3 = w; adr3 = a; wb3 = d;
        end else begin
            sig = s; we = w; adr = a; wb = d;
        end
    endtask

    task automatic access(input bit d3, input bit w, input logic [15:0] a,
                          input logic [7:0] d, input int chg_at,
                          input logic [15:0] a2, input logic [7:0] d2,
                          output logic [7:0] orb, output logic oer, output int lat);
        logic r;
        @(negedge clk);
        drive(d3, 1'b1, w, a, d);
        lat = 0;
        r = 1'b0;
        while (!r && lat < 50) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            r = d3 ? rdy3 : rdy;
            if (!r && lat == chg_at) drive(d3, 1'b1, ~w, a2, d2);
        end
        if (!r) chk("ready_timeout", 32'(r), 32'd1);
        orb = d3 ? rb3 : rb;
        oer = d3 ? err3 : err;
        drive(d3, 1'b0, 1'b0, 16'h0000, 8'h00);
        if (w && a[15:12] == 4'h0) begin
            rmem[int'(d3)][a[11:0]] = d;
            rok[int'(d3)][a[11:0]]  = 1'b1;
        end
    endtask

    // Ready must never stay high for two consecutive cycles.
    bit prev_rdy = 1'b0, prev_rdy3 = 1'b0;
    always @(negedge clk) begin
        if (rdy) chk("ready_gap", 32'(prev_rdy), 32'd0);
        if (rdy3) chk("ready_gap3", 32'(prev_rdy3), 32'd0);
        prev_rdy  = rdy;
        prev_rdy3 = rdy3;
    end

    logic [7:0] orb, exp_rb;
    logic       oer;
    int         lat, cyc, icyc, icyc3, rcyc, n, last;
    logic [15:0] b2b [4];
    logic [7:0]  b2b_exp [4];

    initial begin
        tbl[0]  = '{0, 16'h0050, 8'h00, 8'hF0, 0, 1};
        tbl[1]  = '{0, 16'h009F, 8'h00, 8'h80, 0, 1};
        tbl[2]  = '{0, 16'h0055, 8'h00, 8'h20, 0, 1};
        tbl[3]  = '{1, 16'h0300, 8'hA5, 8'hA5, 0, 1};
        tbl[4]  = '{0, 16'h0300, 8'h00, 8'hA5, 0, 1};
        tbl[5]  = '{1, 16'h0300, 8'h3C, 8'h3C, 0, 1};
        tbl[6]  = '{0, 16'h1300, 8'h00, 8'h00, 1, 1};
        tbl[7]  = '{0, 16'h0300, 8'h00, 8'h3C, 0, 1};
        tbl[8]  = '{1, 16'h1300, 8'hFF, 8'h00, 1, 0};
        tbl[9]  = '{0, 16'h0300, 8'h00, 8'h3C, 0, 1};
        tbl[10] = '{1, 16'h0FFF, 8'h5A, 8'h5A, 0, 1};
        tbl[11] = '{0, 16'h0FFF, 8'h00, 8'h5A, 0, 1};
        tbl[12] = '{1, 16'h0000, 8'hC3, 8'hC3, 0, 1};
        tbl[13] = '{0, 16'h0000, 8'h00, 8'hC3, 0, 1};
        tbl[14] = '{0, 16'hF050, 8'h00, 8'h00, 1, 1};

        for (int i = 0; i < 4096; i++) begin
            rok[0][i] = 1'b0;
            rok[1][i] = 1'b0;
        end
        rst = 1'b1;
        drive(0, 0, 0, 16'h0, 8'h0);
        drive(1, 0, 0, 16'h0, 8'h0);
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rbus", 32'(rb), 32'd0);
        chk("rst_init_done", 32'(idn), 32'd0);
        chk("rst_init_done3", 32'(idn3), 32'd0);

        // Request held from release: stalled through init, then served.
        model_font();
        drive(0, 1, 0, 16'h0050, 8'h00);
        rst = 1'b0;
        cyc = 0; icyc = -1; icyc3 = -1; rcyc = -1;
        while (rcyc < 0 && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (idn && icyc < 0) icyc = cyc;
            if (idn3 && icyc3 < 0) icyc3 = cyc;
            if (rdy) begin
                rcyc = cyc;
                orb = rb;
            end
        end
        drive(0, 0, 0, 16'h0, 8'h0);
        chk("init_cycles", 32'(icyc), 32'd80);
        chk("init_cycles3", 32'(icyc3), 32'd80);
        chk("first_ready_cycle", 32'(rcyc), 32'd82);
        chk("first_ready_rbus", 32'(orb), 32'hF0);

        foreach (tbl[i]) begin
            access(0, tbl[i].w, tbl[i].a, tbl[i].d, 0, 16'h0, 8'h0, orb, oer, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_err", i), 32'(oer), 32'(tbl[i].exp_er));
            if (tbl[i].chk_rb)
                chk($sformatf("vec%0d_rbus", i), 32'(orb), 32'(tbl[i].exp_rb));
        end

        // rbus holds after the response
        access(0, 0, 16'h0300, 8'h00, 0, 16'h0, 8'h0, orb, oer, lat);
        repeat (4) @(negedge clk);
        chk("rbus_hold", 32'(rb), 32'h3C);
        chk("ready_idle", 32'(rdy), 32'd0);

        // Back-to-back reads with the request held high
        b2b[0] = 16'h0050; b2b_exp[0] = 8'hF0;
        b2b[1] = 16'h0055; b2b_exp[1] = 8'h20;
        b2b[2] = 16'h0300; b2b_exp[2] = 8'h3C;
        b2b[3] = 16'h009F; b2b_exp[3] = 8'h80;
        @(negedge clk);
        drive(0, 1, 0, b2b[0], 8'h00);
        n = 0; cyc = 0; last = -1;
        while (n < 4 && cyc < 60) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (rdy) begin
                chk($sformatf("b2b%0d_rbus", n), 32'(rb), 32'(b2b_exp[n]));
                if (n == 0) chk("b2b_first_lat", 32'(cyc), 32'd2);
                else chk($sformatf("b2b%0d_gap", n), 32'(cyc - last), 32'd3);
                last = cyc;
                n++;
                if (n < 4) drive(0, 1, 0, b2b[n], 8'h00);
                else drive(0, 0, 0, 16'h0, 8'h00);
            end
        end
        chk("b2b_count", 32'(n), 32'd4);

        // Wait states; address and data changes mid-access are ignored
        access(1, 0, 16'h0050, 8'h00, 2, 16'h009F, 8'h00, orb, oer, lat);
        chk("w3_read_lat", 32'(lat), 32'd5);
        chk("w3_read_rbus", 32'(orb), 32'hF0);
        access(1, 1, 16'h0310, 8'h12, 1, 16'h0311, 8'hEE, orb, oer, lat);
        chk("w3_write_lat", 32'(lat), 32'd5);
        chk("w3_write_rbus", 32'(orb), 32'h12);
        access(1, 0, 16'h0310, 8'h00, 3, 16'h0050, 8'h00, orb, oer, lat);
        chk("w3_readback", 32'(orb), 32'h12);
        access(1, 0, 16'h2310, 8'h00, 0, 16'h0, 8'h0, orb, oer, lat);
        chk("w3_oor_err", 32'(oer), 32'd1);
        chk("w3_oor_lat", 32'(lat), 32'd5);

        // Random traffic on the zero-wait instance
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            logic [7:0] d;
            bit w, known;
            int r;
            r = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if (r == 0)      a = {4'($urandom_range(1, 15)), 12'($urandom)};
            else if (r < 5)  a = 16'h0300 + 16'($urandom_range(0, 15));
            else if (r < 8)  a = 16'h0050 + 16'($urandom_range(0, 79));
            else             a = {4'h0, 12'($urandom)};
            known = 1'b1;
            if (a[15:12] != 4'h0) exp_rb = 8'h00;
            else if (w) exp_rb = d;
            else begin
                exp_rb = rmem[0][a[11:0]];
                known  = rok[0][a[11:0]];
            end
            if (w && a[15:12] != 4'h0) known = 1'b0;
            access(0, w, a, d, 0, 16'h0, 8'h0, orb, oer, lat);
            chk("rnd_lat", 32'(lat), 32'd2);
            chk("rnd_err", 32'(oer), 32'(a[15:12] != 4'h0));
            if (known) chk("rnd_rbus", 32'(orb), 32'(exp_rb));
        end

        // Reset during the wait states of a write aborts it and reloads the font
        access(1, 1, 16'h0400, 8'h11, 0, 16'h0, 8'h0, orb, oer, lat);
        access(1, 1, 16'h0050, 8'h00, 0, 16'h0, 8'h0, orb, oer, lat);
        access(1, 0, 16'h0050, 8'h00, 0, 16'h0, 8'h0, orb, oer, lat);
        chk("font_overwritten", 32'(orb), 32'h00);
        @(negedge clk);
        drive(1, 1, 1, 16'h0400, 8'h77);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        drive(1, 0, 0, 16'h0, 8'h0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_ready", 32'(rdy3), 32'd0);
        end
        chk("abort_init_done", 32'(idn3), 32'd0);
        chk("abort_rbus", 32'(rb3), 32'd0);
        rst = 1'b0;
        model_font();
        cyc = 0; icyc3 = -1;
        while (icyc3 < 0 && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (idn3) icyc3 = cyc;
        end
        chk("reinit_cycles", 32'(icyc3), 32'd80);
        access(1, 0, 16'h0400, 8'h00, 0, 16'h0, 8'h0, orb, oer, lat);
        chk("aborted_write", 32'(orb), 32'h11);
        access(1, 0, 16'h0050, 8'h00, 0, 16'h0, 8'h0, orb, oer, lat);
        chk("font_reloaded", 32'(orb), 32'(rmem[1][12'h050]));
        chk("font_reloaded_lat", 32'(lat), 32'd5);
        access(1, 0, 16'h0310, 8'h00, 0, 16'h0, 8'h0, orb, oer, lat);
        chk("retained", 32'(orb), 32'(rmem[1][12'h310]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
